// File: rtl/touch_adc_responder.sv
// Chip-side model of a serial touch-screen ADC: decodes the master's control byte,
// flags a one-period conversion, then shifts back a snapshotted 12- or 8-bit sample.
module touch_adc_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        cclk,
  input  logic        rstb,
  input  logic        touch_clk,
  input  logic        touch_csb,
  input  logic        touch_data_in,
  output logic        touch_data_out,
  output logic        touch_busy,
  input  logic [11:0] x_val,
  input  logic [11:0] y_val,
  input  logic [11:0] z1_val,
  input  logic [11:0] z2_val,
  output logic [7:0]  cmd_byte,
  output logic        cmd_valid
);

  typedef enum logic [2:0] {
    IDLE, WAIT_S, CMD, CMD_DONE, CONV, SHIFT, TAIL
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, csb_sync_q, din_sync_q;
  logic                   clk_a_q, clk_b_q, csb_a_q, din_a_q;

  // csb chain resets high so a released reset never looks like a selected frame.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      clk_sync_q <= '0;
      csb_sync_q <= '1;
      din_sync_q <= '0;
      clk_a_q    <= 1'b0;
      clk_b_q    <= 1'b0;
      csb_a_q    <= 1'b1;
      din_a_q    <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], touch_clk};
      csb_sync_q <= {csb_sync_q[SYNC_STAGES-2:0], touch_csb};
      din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], touch_data_in};
      clk_a_q    <= clk_sync_q[SYNC_STAGES-1];
      clk_b_q    <= clk_a_q;
      csb_a_q    <= csb_sync_q[SYNC_STAGES-1];
      din_a_q    <= din_sync_q[SYNC_STAGES-1];
    end
  end

  logic rise, fall;
  assign rise = clk_a_q & ~clk_b_q;
  assign fall = ~clk_a_q & clk_b_q;

  state_t      state_q, state_d;
  logic [6:0]  cmd_sr_q, cmd_sr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [11:0] sample_q, sample_d;
  logic [3:0]  rem_q, rem_d;
  logic        dout_q, dout_d;
  logic        busy_q, busy_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic        cmd_valid_q, cmd_valid_d;

  logic [7:0]  new_byte;
  logic [11:0] chan_val;

  assign new_byte = {cmd_sr_q, din_a_q};

  always_comb begin
    case (new_byte[6:4])
      3'b101:  chan_val = x_val;
      3'b001:  chan_val = y_val;
      3'b011:  chan_val = z1_val;
      3'b100:  chan_val = z2_val;
      default: chan_val = 12'h000;
    endcase
  end

  always_comb begin
    // NOTE: every _d signal takes a default first, so no branch can infer a latch.
    state_d     = state_q;
    cmd_sr_d    = cmd_sr_q;
    bit_cnt_d   = bit_cnt_q;
    sample_d    = sample_q;
    rem_d       = rem_q;
    dout_d      = dout_q;
    busy_d      = busy_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;

    if (csb_a_q) begin
      state_d   = IDLE;
      cmd_sr_d  = '0;
      bit_cnt_d = '0;
      sample_d  = '0;
      rem_d     = '0;
      dout_d    = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_S;
        // TAIL accepts a fresh start bit exactly like WAIT_S; leading zeros are skipped.
        WAIT_S, TAIL: begin
          if (rise && din_a_q) begin
            cmd_sr_d  = 7'h01;
            bit_cnt_d = 3'd1;
            state_d   = CMD;
          end
        end
        CMD: begin
          if (rise) begin
            cmd_sr_d  = new_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              cmd_byte_d  = new_byte;
              cmd_valid_d = 1'b1;
              sample_d    = new_byte[3] ? {chan_val[11:4], 4'h0} : chan_val;
              state_d     = CMD_DONE;
            end
          end
        end
        CMD_DONE: begin
          if (fall) begin
            busy_d  = 1'b1;
            state_d = CONV;
          end
        end
        CONV: begin
          if (fall) begin
            busy_d   = 1'b0;
            dout_d   = sample_q[11];
            sample_d = {sample_q[10:0], 1'b0};
            rem_d    = cmd_byte_q[3] ? 4'd7 : 4'd11;
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          if (fall) begin
            if (rem_q != 4'd0) begin
              dout_d   = sample_q[11];
              sample_d = {sample_q[10:0], 1'b0};
              rem_d    = rem_q - 4'd1;
            end else begin
              dout_d  = 1'b0;
              state_d = TAIL;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= IDLE;
      cmd_sr_q    <= '0;
      bit_cnt_q   <= '0;
      sample_q    <= '0;
      rem_q       <= '0;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_byte_q  <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_sr_q    <= cmd_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      sample_q    <= sample_d;
      rem_q       <= rem_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign touch_data_out = dout_q;
  assign touch_busy     = busy_q;
  assign cmd_byte       = cmd_byte_q;
  assign cmd_valid      = cmd_valid_q;

endmodule
